// File: rtl/clock_display_pkg.sv
// clock_display_pkg: digit codes, converter states and 7-segment patterns for the clock display
package clock_display_pkg;
  typedef logic [3:0] digit_t;
  localparam digit_t DIG_DASH  = 4'd10;
  localparam digit_t DIG_BLANK = 4'd11;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_COMMIT} conv_state_e;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: digit code to active-high {g,f,e,d,c,b,a} segment pattern
module seg7_decode
  import clock_display_pkg::*;
(
  input  digit_t     code,
  output logic [6:0] seg
);
  always_comb begin
    case (code)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      DIG_DASH: seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/clock_display_scan.sv
// clock_display_scan: binary time to BCD and 4-digit multiplexed 7-segment scan with set-mode blink
module clock_display_scan
  import clock_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 10,
  parameter int unsigned BLINK_DIV      = 2500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_10000Hz,
  input  logic        rst,
  input  logic [13:0] hours_in,
  input  logic [13:0] minutes_in,
  input  logic [13:0] seconds_in,
  input  logic        show_min_sec,
  input  logic        setting_enable,
  input  logic        set_hr_or_min,
  output logic [6:0]  seg_out,
  output logic        dp_out,
  output logic [3:0]  digit_sel
);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0] idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_q, blink_d;
  conv_state_e state_q, state_d;
  logic [13:0] val_a_q, val_a_d, val_b_q, val_b_d;
  logic [3:0] tens_a_q, tens_a_d, tens_b_q, tens_b_d;
  logic inv_a_q, inv_a_d, inv_b_q, inv_b_d;
  digit_t [3:0] dig_q, dig_d, disp_q, disp_d;
  logic [6:0] seg_q, seg_d, seg_pat;
  logic dp_q, dp_d;
  logic [3:0] sel_q, sel_d;
  logic scan_tc, frame_wrap, blink_tc, mm_ss, done_a, done_b, blank_now;
  logic [13:0] left_sel, right_sel;
  digit_t shown;
  always_comb begin
    scan_tc     = presc_q == PW'(SCAN_DIV - 1);
    frame_wrap  = scan_tc && idx_q == 2'd3;
    presc_d     = scan_tc ? '0 : presc_q + 1'b1;
    idx_d       = scan_tc ? idx_q + 2'd1 : idx_q;
    blink_tc    = blink_cnt_q == BW'(BLINK_DIV - 1);
    blink_cnt_d = blink_tc ? '0 : blink_cnt_q + 1'b1;
    blink_d     = blink_q ^ blink_tc;
    mm_ss       = show_min_sec && !setting_enable;
    left_sel    = mm_ss ? minutes_in : hours_in;
    right_sel   = mm_ss ? seconds_in : minutes_in;
    // committed digits reach the display only at a frame boundary, so a frame is never torn
    disp_d      = frame_wrap ? dig_q : disp_q;
    blank_now   = setting_enable && blink_d && (idx_d[1] == set_hr_or_min);
    shown       = blank_now ? DIG_BLANK : disp_d[idx_d];
    seg_d       = seg_pat ^ {7{SEG_ACTIVE_LOW}};
    dp_d        = (idx_d == 2'd1 && (setting_enable || !seconds_in[0])) ^ SEG_ACTIVE_LOW;
    sel_d       = (4'b1000 >> idx_d) ^ {4{DIG_ACTIVE_LOW}};
  end
  seg7_decode u_dec (.code(shown), .seg(seg_pat));
  always_comb begin
    state_d  = state_q;
    val_a_d  = val_a_q;
    val_b_d  = val_b_q;
    tens_a_d = tens_a_q;
    tens_b_d = tens_b_q;
    inv_a_d  = inv_a_q;
    inv_b_d  = inv_b_q;
    dig_d    = dig_q;
    done_a   = inv_a_q || val_a_q < 14'd10;
    done_b   = inv_b_q || val_b_q < 14'd10;
    case (state_q)
      S_IDLE: state_d = frame_wrap ? S_LOAD : S_IDLE;
      S_LOAD: begin
        val_a_d  = left_sel;
        val_b_d  = right_sel;
        tens_a_d = '0;
        tens_b_d = '0;
        inv_a_d  = 1'b0;
        inv_b_d  = 1'b0;
        state_d  = S_CONV;
      end
      S_CONV: begin
        state_d  = (done_a && done_b) ? S_COMMIT : S_CONV;
        val_a_d  = done_a ? val_a_q : val_a_q - 14'd10;
        tens_a_d = done_a ? tens_a_q : tens_a_q + 4'd1;
        inv_a_d  = inv_a_q || (!done_a && tens_a_q == 4'd9);
        val_b_d  = done_b ? val_b_q : val_b_q - 14'd10;
        tens_b_d = done_b ? tens_b_q : tens_b_q + 4'd1;
        inv_b_d  = inv_b_q || (!done_b && tens_b_q == 4'd9);
      end
      S_COMMIT: begin
        dig_d[0] = inv_a_q ? DIG_DASH : tens_a_q;
        dig_d[1] = inv_a_q ? DIG_DASH : val_a_q[3:0];
        dig_d[2] = inv_b_q ? DIG_DASH : tens_b_q;
        dig_d[3] = inv_b_q ? DIG_DASH : val_b_q[3:0];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_10000Hz or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      state_q     <= S_IDLE;
      val_a_q     <= '0;
      val_b_q     <= '0;
      tens_a_q    <= '0;
      tens_b_q    <= '0;
      inv_a_q     <= 1'b0;
      inv_b_q     <= 1'b0;
      dig_q       <= {4{DIG_BLANK}};
      disp_q      <= {4{DIG_BLANK}};
      seg_q       <= {7{SEG_ACTIVE_LOW}};
      dp_q        <= SEG_ACTIVE_LOW;
      sel_q       <= {4{DIG_ACTIVE_LOW}};
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      state_q     <= state_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      tens_a_q    <= tens_a_d;
      tens_b_q    <= tens_b_d;
      inv_a_q     <= inv_a_d;
      inv_b_q     <= inv_b_d;
      dig_q       <= dig_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      sel_q       <= sel_d;
    end
  end
  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign digit_sel = sel_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan: scoreboard bench; expected frames queued by stimulus, compared by a frame monitor
module tb_clock_display_scan;
  logic clk = 1'b0;
  logic rst;
  logic [13:0] hours_in, minutes_in, seconds_in;
  logic show_min_sec, setting_enable, set_hr_or_min;
  logic [6:0] seg_out;
  logic dp_out;
  logic [3:0] digit_sel;
  localparam logic [3:0] B = 4'd11;
  localparam logic [3:0] D = 4'd10;
  typedef struct {
    string           name;
    logic [3:0][3:0] d;
    logic [3:0]      dpm;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int mon_start, mon_n;
  int checks = 0, errors = 0, cyc = 0, frame_cnt = 0;
  logic busy = 1'b0;
  logic [3:0][6:0] cur_seg, snap_seg;
  logic [3:0] cur_dp, snap_dp, prev_act;

  clock_display_scan dut (
    .clk_10000Hz(clk), .rst(rst), .hours_in(hours_in), .minutes_in(minutes_in),
    .seconds_in(seconds_in), .show_min_sec(show_min_sec), .setting_enable(setting_enable),
    .set_hr_or_min(set_hr_or_min), .seg_out(seg_out), .dp_out(dp_out), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

  function automatic logic [6:0] seg_of(logic [3:0] c);
    case (c)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      4'd10: return 7'b1000000;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // frame recorder: snapshot a whole frame when slot 0 follows slot 3
  always @(negedge clk) begin
    if ((~digit_sel) == 4'b1000 && prev_act == 4'b0001) begin
      snap_seg  <= cur_seg;
      snap_dp   <= cur_dp;
      frame_cnt <= frame_cnt + 1;
    end
    for (int i = 0; i < 4; i++)
      if ((~digit_sel) == (4'b1000 >> i)) begin
        cur_seg[i] <= ~seg_out;
        cur_dp[i]  <= ~dp_out;
      end
    prev_act <= ~digit_sel;
  end

  // monitor: compare the first frame lying entirely after the expectation was popped
  initial begin
    forever begin
      @(posedge clk);
      if (exp_q.size() != 0) begin
        busy = 1'b1;
        mon_e = exp_q.pop_front();
        mon_start = frame_cnt;
        mon_n = 0;
        while (frame_cnt < mon_start + 2 && mon_n < 400) begin
          @(posedge clk);
          mon_n++;
        end
        if (frame_cnt < mon_start + 2) begin
          checks++;
          errors++;
          $display("FAIL %s frame timeout got=%0d frames want=2", mon_e.name, frame_cnt - mon_start);
        end else
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s seg%0d", mon_e.name, i), snap_seg[i], seg_of(mon_e.d[i]));
            chk($sformatf("%s dp%0d", mon_e.name, i), snap_dp[i], mon_e.dpm[i]);
          end
        busy = 1'b0;
      end
    end
  end

  task automatic expect_frame(string name, logic [3:0] d0, d1, d2, d3, logic dp1);
    exp_t e;
    e.name = name;
    e.d    = {d3, d2, d1, d0};
    e.dpm  = {2'b00, dp1, 1'b0};
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain timeout got=%0d pending want=0", exp_q.size());
    end
  endtask

  task automatic wait_slot0();
    int n = 1;
    logic [3:0] prev;
    prev = digit_sel;
    @(negedge clk);
    while (!(prev == 4'b1110 && digit_sel != 4'b1110) && n < 100) begin
      prev = digit_sel;
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL slot0 timeout got=%0h want=7", digit_sel);
    end
  endtask

  task automatic wait_blink_mid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc % 2500 != 1000 && n < 6000);
    if (n >= 6000) begin
      checks++;
      errors++;
      $display("FAIL blink align timeout got=%0d want=1000", cyc % 2500);
    end
  endtask

  initial begin
    int ph;
    rst = 1'b1;
    hours_in = '0; minutes_in = '0; seconds_in = '0;
    show_min_sec = 1'b0; setting_enable = 1'b0; set_hr_or_min = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset seg", seg_out, 7'h7f);
    chk("reset dp", dp_out, 1'b1);
    chk("reset sel", digit_sel, 4'hf);
    rst = 1'b0;
    hours_in = 14'd13; minutes_in = 14'd7; seconds_in = 14'd1;
    repeat (120) @(negedge clk);
    wait_slot0();
    chk("slot0 sel", digit_sel, 4'b0111);
    chk("slot0 seg", seg_out, 7'h79);
    expect_frame("hhmm 13:07", 4'd1, 4'd3, 4'd0, 4'd7, 1'b0);
    drain();
    show_min_sec = 1'b1; minutes_in = 14'd59; seconds_in = 14'd42;
    repeat (100) @(negedge clk);
    expect_frame("mmss 59:42", 4'd5, 4'd9, 4'd4, 4'd2, 1'b1);
    drain();
    seconds_in = 14'd43;
    repeat (100) @(negedge clk);
    expect_frame("mmss 59:43", 4'd5, 4'd9, 4'd4, 4'd3, 1'b0);
    drain();
    show_min_sec = 1'b0; hours_in = 14'd24; minutes_in = 14'd60;
    repeat (100) @(negedge clk);
    expect_frame("hhmm 24:60", 4'd2, 4'd4, 4'd6, 4'd0, 1'b0);
    drain();
    hours_in = 14'd100;
    repeat (100) @(negedge clk);
    expect_frame("hours 100", D, D, 4'd6, 4'd0, 1'b0);
    drain();
    hours_in = 14'd16383; minutes_in = 14'd5;
    repeat (100) @(negedge clk);
    expect_frame("hours max", D, D, 4'd0, 4'd5, 1'b0);
    drain();
    hours_in = 14'd99; minutes_in = 14'd100;
    repeat (100) @(negedge clk);
    expect_frame("mins 100", 4'd9, 4'd9, D, D, 1'b0);
    drain();
    setting_enable = 1'b1; set_hr_or_min = 1'b1; show_min_sec = 1'b1;
    hours_in = 14'd13; minutes_in = 14'd7;
    repeat (100) @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      set_hr_or_min = r < 2;
      wait_blink_mid();
      ph = (cyc / 2500) % 2;
      expect_frame($sformatf("blink r%0d ph%0d", r, ph),
                   (ph == 1 && r >= 2) ? B : 4'd1, (ph == 1 && r >= 2) ? B : 4'd3,
                   (ph == 1 && r < 2) ? B : 4'd0, (ph == 1 && r < 2) ? B : 4'd7, 1'b1);
      drain();
    end
    setting_enable = 1'b0; show_min_sec = 1'b0; minutes_in = 14'd23;
    repeat (100) @(negedge clk);
    wait_slot0();
    repeat (6) @(negedge clk);
    minutes_in = 14'd48;
    expect_frame("midconv old", 4'd1, 4'd3, 4'd2, 4'd3, 1'b0);
    expect_frame("midconv new", 4'd1, 4'd3, 4'd4, 4'd8, 1'b0);
    drain();
    seconds_in = 14'd42;
    repeat (50) @(negedge clk);
    wait_slot0();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midconv rst seg", seg_out, 7'h7f);
    chk("midconv rst dp", dp_out, 1'b1);
    chk("midconv rst sel", digit_sel, 4'hf);
    @(negedge clk);
    rst = 1'b0;
    expect_frame("post rst blank", B, B, B, B, 1'b1);
    expect_frame("post rst digits", 4'd1, 4'd3, 4'd4, 4'd8, 1'b1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_display_scan.md
Name: clock_display_scan

Overview:
Downstream consumer of the time-of-day counter. Converts its binary hours/minutes/seconds outputs to BCD and drives a 4-digit multiplexed 7-segment display.
- Shows HH.MM or MM.SS.
- Blinks the field being edited in set mode.
- Provides a seconds-tick decimal point.
- Runs on the same 10 kHz clock domain as the counter.

Parameters:
SCAN_DIV, 10, clock cycles per digit slot (1 kHz digit rate, 250 Hz frame)
BLINK_DIV, 2500, cycles per blink half-period (2 Hz blink)
SEG_ACTIVE_LOW, 1, 1 = segment outputs inverted at pins
DIG_ACTIVE_LOW, 1, 1 = digit enables inverted at pins

Ports:
clk_10000Hz  input  1  system clock, 10 kHz
rst  input  1  asynchronous, active-high reset
hours_in  input  14  binary hours from counter
minutes_in  input  14  binary minutes from counter
seconds_in  input  14  binary seconds from counter
show_min_sec  input  1  0 = HH.MM, 1 = MM.SS
setting_enable  input  1  counter is in set mode
set_hr_or_min  input  1  field being set: 0 = hours, 1 = minutes
seg_out  output  7  segments {g,f,e,d,c,b,a}
dp_out  output  1  decimal point
digit_sel  output  4  one-hot digit enable; bit3 = leftmost digit

Behaviour:
- Reset (asynchronous, active-high):
  - All registers clear.
  - seg_out, dp_out and digit_sel drive the inactive level.
  - Scan index = 0; blink phase = 0; converter in IDLE.
  - All four digit registers hold BLANK, so the display stays dark until the first conversion completes.
  - Reset mid-conversion aborts it; no partial result is committed.
- Scan timing:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count, scan index advances 0→1→2→3→0.
  - Index 0 = leftmost digit (digit_sel bit3).
  - seg_out, dp_out and digit_sel are registered and change on the same edge (no ghosting skew).
- Field selection:
  - setting_enable=1 forces HH.MM regardless of show_min_sec.
  - Otherwise: left pair = hours (show_min_sec=0) or minutes (show_min_sec=1); right pair = minutes or seconds.
- Converter FSM (IDLE, LOAD, CONV, COMMIT):
  - IDLE→LOAD when scan index wraps 3→0 at prescaler terminal.
  - LOAD: latch both selected 14-bit fields; clear both tens counters. Next state CONV.
  - CONV: each field in parallel, per cycle: if value ≥ 10, subtract 10 and increment tens; else hold.
    - If a tens counter reaches 10, that field is flagged invalid.
    - CONV→COMMIT when both fields are <10 or flagged.
    - Worst case: 11 cycles.
  - COMMIT: write all four digit registers atomically, then IDLE.
    - Invalid field (input ≥ 100) commits DASH, DASH.
  - Total latency LOAD→COMMIT ≤ 13 cycles < 40-cycle frame, so no overlap and no torn display.
  - A new value appears on the frame after the one in which it is latched.
- Blink:
  - Counter 0..BLINK_DIV-1 toggles blink phase at terminal; free-running.
  - When setting_enable=1 and blink phase=1, the selected field's two digits show BLANK (digit_sel still scans).
  - Field selection: hours → digits 0,1; minutes → digits 2,3.
  - Blink is never applied when setting_enable=0.
- Decimal point (digit 1 only):
  - setting_enable=1: always lit.
  - Otherwise lit when seconds_in[0]==0; registered from the current input, not the snapshot.
- Segment codes (active-high, before polarity inversion):
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111, 4:1100110
  - 5:1101101, 6:1111101, 7:0000111, 8:1111111, 9:1101111
  - DASH:1000000, BLANK:0000000
- Leading zero is shown (07, not blank-7).
- Simultaneous events: a conversion start and a blink toggle on the same edge are independent; blanking applies to committed digit values.

Decomposition:
- Package clock_display_pkg holds:
  - Digit code type: 4-bit; 0-9 digits, 10 = DASH, 11 = BLANK.
  - Converter state encoding.
  - The segment pattern constants.
- One sub-module, seg7_decode: combinational 4-bit code → 7-bit active-high pattern.

Test Plan:
- Reset, then hours_in=13, minutes_in=7, show_min_sec=0, setting_enable=0 → within 2 frames (80 cycles), digits 0..3 = 1,3,0,7. Slot 0 seg_out=~0000110, digit_sel=4'b0111 (both active-low).
- show_min_sec=1, minutes_in=59, seconds_in=42 → digits 5,9,4,2. dp_out lit on digit 1 only when seconds_in even.
- hours_in=24, minutes_in=60 → displays 2,4,6,0. hours_in=100 → left pair DASH, DASH; right pair unaffected.
- setting_enable=1, set_hr_or_min=1, show_min_sec=1 → HH.MM forced. Minutes digits blank for 2500 cycles, shown for 2500; hours always lit; dp on digit 1 constant.
- Change minutes_in mid-conversion (cycle 5 after LOAD) → committed value is the LOAD-time value. Next frame shows the new value; never mixed digits.
- Assert rst mid-CONV and mid-scan → outputs inactive on the same cycle. After release, blank until first COMMIT, then correct digits.
